// File: rtl/t2mi_pps_pkg.sv
// rtl/t2mi_pps_pkg.sv - shared widths, lock-state encoding and subsecond scaling for the T2-MI sync path
package t2mi_pps_pkg;

    localparam int SEC_W    = 40;
    localparam int SUBSEC_W = 32;
    localparam int CYC_W    = 27;

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;
    localparam logic [1:0] ST_HOLDOVER = 2'd3;

    // Convert a 2^-32 s fraction into whole clock cycles into the second (floor)
    function automatic logic [CYC_W-1:0] subsec_to_cyc(input logic [SUBSEC_W-1:0] subsec,
                                                        input logic [31:0]         clk_freq_hz);
        return CYC_W'(({32'd0, subsec} * {32'd0, clk_freq_hz}) >> SUBSEC_W);
    endfunction

endpackage

// File: rtl/t2mi_phase_check.sv
// rtl/t2mi_phase_check.sv - two-stage timestamp vs local-second phase comparison pipeline
module t2mi_phase_check
    import t2mi_pps_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ   = 100_000_000,
    parameter int unsigned PHASE_TOL_CYC = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [SEC_W-1:0]    in_seconds,
    input  logic [SUBSEC_W-1:0] in_subseconds,
    input  logic                pps_tick,
    input  logic [CYC_W-1:0]    cyc_cnt,
    input  logic [SEC_W-1:0]    pred_sec,
    output logic                busy,
    output logic                out_valid,
    output logic                out_consistent,
    output logic [SEC_W-1:0]    out_seconds,
    output logic [CYC_W-1:0]    out_exp,
    output logic [CYC_W:0]      out_phase_err
);

    localparam logic [CYC_W:0] TOL  = (CYC_W+1)'(PHASE_TOL_CYC);
    localparam logic [31:0]    FREQ = 32'(CLK_FREQ_HZ);

    logic             s1_valid_q, s1_valid_d;
    logic [SEC_W-1:0] s1_sec_q, s1_sec_d, s1_pred_q, s1_pred_d;
    logic [CYC_W-1:0] s1_exp_q, s1_exp_d, s1_meas_q, s1_meas_d;
    logic             s2_valid_q, s2_valid_d, s2_cons_q, s2_cons_d;
    logic [SEC_W-1:0] s2_sec_q, s2_sec_d;
    logic [CYC_W-1:0] s2_exp_q, s2_exp_d;
    logic [CYC_W:0]   perr_q, perr_d, perr, perr_abs;

    // Stage 1: capture expected phase and local cycle count; a coincident tick means second boundary now
    always_comb begin
        s1_valid_d = in_valid;
        s1_sec_d   = s1_sec_q;
        s1_pred_d  = s1_pred_q;
        s1_exp_d   = s1_exp_q;
        s1_meas_d  = s1_meas_q;
        if (in_valid) begin
            s1_sec_d  = in_seconds;
            s1_pred_d = pps_tick ? pred_sec + SEC_W'(1) : pred_sec;
            s1_exp_d  = subsec_to_cyc(in_subseconds, FREQ);
            s1_meas_d = pps_tick ? '0 : cyc_cnt;
        end
    end

    // Stage 2: signed phase error and consistency verdict
    always_comb begin
        perr       = {1'b0, s1_exp_q} - {1'b0, s1_meas_q};
        perr_abs   = perr[CYC_W] ? ((CYC_W+1)'(0) - perr) : perr;
        s2_valid_d = s1_valid_q;
        s2_cons_d  = s2_cons_q;
        s2_sec_d   = s2_sec_q;
        s2_exp_d   = s2_exp_q;
        perr_d     = perr_q;
        if (s1_valid_q) begin
            s2_cons_d = (s1_sec_q == s1_pred_q) && (perr_abs <= TOL);
            s2_sec_d  = s1_sec_q;
            s2_exp_d  = s1_exp_q;
            perr_d    = perr;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sec_q   <= '0;
            s1_pred_q  <= '0;
            s1_exp_q   <= '0;
            s1_meas_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_cons_q  <= 1'b0;
            s2_sec_q   <= '0;
            s2_exp_q   <= '0;
            perr_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sec_q   <= s1_sec_d;
            s1_pred_q  <= s1_pred_d;
            s1_exp_q   <= s1_exp_d;
            s1_meas_q  <= s1_meas_d;
            s2_valid_q <= s2_valid_d;
            s2_cons_q  <= s2_cons_d;
            s2_sec_q   <= s2_sec_d;
            s2_exp_q   <= s2_exp_d;
            perr_q     <= perr_d;
        end
    end

    assign busy           = s1_valid_q | s2_valid_q;
    assign out_valid      = s2_valid_q;
    assign out_consistent = s2_cons_q;
    assign out_seconds    = s2_sec_q;
    assign out_exp        = s2_exp_q;
    assign out_phase_err  = perr_q;

endmodule

// File: rtl/t2mi_sync_controller.sv
// rtl/t2mi_sync_controller.sv - T2-MI lock FSM and PPS load handshake; optional PHASE_TRIM_EN adds trim loads in LOCKED
module t2mi_sync_controller
    import t2mi_pps_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
    parameter int unsigned LOCK_COUNT     = 3,
    parameter int unsigned PHASE_TOL_CYC  = 100,
    parameter int unsigned MISS_LIMIT     = 3,
    parameter int unsigned TS_TIMEOUT_PPS = 2,
    parameter int unsigned HOLDOVER_LIMIT = 10
) (
    input  logic                clk_100mhz,
    input  logic                rst,
    input  logic                ts_valid,
    input  logic [SEC_W-1:0]    ts_seconds,
    input  logic [SUBSEC_W-1:0] ts_subseconds,
    input  logic                pps_tick,
    output logic                load_req,
    output logic [SEC_W-1:0]    load_seconds,
    output logic [CYC_W-1:0]    load_phase_cyc,
    input  logic                load_ack,
    output logic                sync_locked,
    output logic                holdover,
    output logic [1:0]          state,
    output logic [CYC_W:0]      phase_err,
    output logic [7:0]          err_count
);

    localparam logic [CYC_W:0] FREQ_CYC = (CYC_W+1)'(CLK_FREQ_HZ);
    localparam logic [7:0]     LOCK_N   = 8'(LOCK_COUNT);
    localparam logic [7:0]     MISS_N   = 8'(MISS_LIMIT);
    localparam logic [7:0]     TO_N     = 8'(TS_TIMEOUT_PPS);
    localparam logic [7:0]     HOLD_N   = 8'(HOLDOVER_LIMIT);

    logic [CYC_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [SEC_W-1:0] pred_sec_q, pred_sec_d;
    logic [1:0]       state_q, state_d;
    logic [7:0]       good_q, good_d, miss_q, miss_d, to_cnt_q, to_cnt_d, err_q, err_d;
    logic             load_req_q, load_req_d;
    logic [SEC_W-1:0] load_sec_q, load_sec_d;
    logic [CYC_W-1:0] load_phase_q, load_phase_d;

    logic             chk_busy, chk_valid, chk_consistent;
    logic [SEC_W-1:0] chk_seconds;
    logic [CYC_W-1:0] chk_exp;
    logic [CYC_W:0]   chk_phase_err;
    logic             ts_accept, ts_drop, issue, reject, load_fire, timeout, wrap;
    logic [CYC_W:0]   phase_sum;
    logic [CYC_W-1:0] next_phase;
    logic [SEC_W-1:0] next_sec;
    logic [7:0]       to_next;
    logic [8:0]       err_sum;

    assign ts_accept = ts_valid && !chk_busy && !load_req_q;
    assign ts_drop   = ts_valid && !ts_accept;

    t2mi_phase_check #(
        .CLK_FREQ_HZ  (CLK_FREQ_HZ),
        .PHASE_TOL_CYC(PHASE_TOL_CYC)
    ) u_phase_check (
        .clk           (clk_100mhz),
        .rst           (rst),
        .in_valid      (ts_accept),
        .in_seconds    (ts_seconds),
        .in_subseconds (ts_subseconds),
        .pps_tick      (pps_tick),
        .cyc_cnt       (cyc_cnt_q),
        .pred_sec      (pred_sec_q),
        .busy          (chk_busy),
        .out_valid     (chk_valid),
        .out_consistent(chk_consistent),
        .out_seconds   (chk_seconds),
        .out_exp       (chk_exp),
        .out_phase_err (chk_phase_err)
    );

    // Load target: advance by the 3-cycle decision latency, rolling into the next second on wrap
    always_comb begin
        phase_sum  = {1'b0, chk_exp} + (CYC_W+1)'(3);
        wrap       = (phase_sum >= FREQ_CYC);
        next_phase = wrap ? CYC_W'(phase_sum - FREQ_CYC) : phase_sum[CYC_W-1:0];
        next_sec   = chk_seconds + SEC_W'(wrap);
    end

    // Lock FSM: a timestamp decision always takes precedence over a tick timeout
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        miss_d  = miss_q;
        issue   = 1'b0;
        reject  = 1'b0;
        to_next = (to_cnt_q == 8'hFF) ? to_cnt_q : to_cnt_q + 8'd1;
        timeout = pps_tick && (to_next >= ((state_q == ST_HOLDOVER) ? HOLD_N : TO_N));
        case (state_q)
            ST_UNLOCKED: begin
                if (chk_valid) begin
                    issue   = 1'b1;
                    state_d = ST_ACQUIRE;
                    good_d  = '0;
                end
            end
            ST_ACQUIRE: begin
                if (chk_valid) begin
                    if (chk_consistent) begin
                        good_d = good_q + 8'd1;
                        if (good_q + 8'd1 == LOCK_N) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        reject = 1'b1;
                        issue  = 1'b1;
                        good_d = '0;
                    end
                end else if (timeout) begin
                    state_d = ST_UNLOCKED;
                end
            end
            ST_LOCKED: begin
                if (chk_valid) begin
                    if (chk_consistent) begin
                        miss_d = '0;
`ifdef PHASE_TRIM_EN
                        if (chk_phase_err != '0) issue = 1'b1;
`endif
                    end else begin
                        reject = 1'b1;
                        if (miss_q + 8'd1 == MISS_N) begin
                            state_d = ST_UNLOCKED;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + 8'd1;
                        end
                    end
                end else if (timeout) begin
                    state_d = ST_HOLDOVER;
                end
            end
            default: begin
                if (chk_valid) begin
                    if (chk_consistent) begin
                        state_d = ST_LOCKED;
                        miss_d  = '0;
                    end else begin
                        issue   = 1'b1;
                        state_d = ST_ACQUIRE;
                        good_d  = '0;
                    end
                end else if (timeout) begin
                    state_d = ST_UNLOCKED;
                end
            end
        endcase
    end

    // Counters, predicted second, handshake and error tally
    always_comb begin
        load_fire = issue && !load_req_q;

        cyc_cnt_d = cyc_cnt_q;
        if (pps_tick) cyc_cnt_d = '0;
        else if (cyc_cnt_q != '1) cyc_cnt_d = cyc_cnt_q + CYC_W'(1);

        pred_sec_d = pred_sec_q;
        if (load_fire) pred_sec_d = next_sec;
        else if (pps_tick) pred_sec_d = pred_sec_q + SEC_W'(1);

        to_cnt_d = to_cnt_q;
        if (chk_valid || (state_d != state_q)) to_cnt_d = '0;
        else if (pps_tick) to_cnt_d = to_next;

        load_req_d   = load_req_q;
        load_sec_d   = load_sec_q;
        load_phase_d = load_phase_q;
        if (load_req_q && load_ack) load_req_d = 1'b0;
        if (load_fire) begin
            load_req_d   = 1'b1;
            load_sec_d   = next_sec;
            load_phase_d = next_phase;
        end

        err_sum = {1'b0, err_q} + {8'd0, ts_drop} + {8'd0, reject};
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // State registers
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            cyc_cnt_q    <= '0;
            pred_sec_q   <= '0;
            state_q      <= ST_UNLOCKED;
            good_q       <= '0;
            miss_q       <= '0;
            to_cnt_q     <= '0;
            err_q        <= '0;
            load_req_q   <= 1'b0;
            load_sec_q   <= '0;
            load_phase_q <= '0;
        end else begin
            cyc_cnt_q    <= cyc_cnt_d;
            pred_sec_q   <= pred_sec_d;
            state_q      <= state_d;
            good_q       <= good_d;
            miss_q       <= miss_d;
            to_cnt_q     <= to_cnt_d;
            err_q        <= err_d;
            load_req_q   <= load_req_d;
            load_sec_q   <= load_sec_d;
            load_phase_q <= load_phase_d;
        end
    end

    assign load_req       = load_req_q;
    assign load_seconds   = load_sec_q;
    assign load_phase_cyc = load_phase_q;
    assign state          = state_q;
    assign sync_locked    = (state_q == ST_LOCKED);
    assign holdover       = (state_q == ST_HOLDOVER);
    assign phase_err      = chk_phase_err;
    assign err_count      = err_q;

endmodule
